// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared definitions for the ALU operand/writeback stage: ALU opcode
//   values, the opcode legality check and the stage FSM state type.
package alu_issue_stage_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b0100;
   localparam logic [3:0] OP_ASR = 4'b1000;
   localparam logic [3:0] OP_SLL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_ROL = 4'b1100;
   localparam logic [3:0] OP_ROR = 4'b1101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WB,
      ST_LDWB,
      ST_ERR
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
         OP_ASR, OP_SLL, OP_SRL, OP_ROL, OP_ROR: is_legal_op = 1'b1;
         default:                                is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// alu_issue_stage_regfile
//   Architectural register file: two combinational operand read ports, one
//   combinational debug read port, one synchronous write port, asynchronous
//   active-low clear. Register 0 always reads zero and ignores writes.
// Ports:
//   clk, rst_n            clock / async active-low clear
//   ra_addr -> ra_data    operand A read
//   rb_addr -> rb_data    operand B read
//   dbg_addr -> dbg_data  debug read
//   we, wa, wd            write enable / index / data (posedge)
module alu_issue_stage_regfile
   import alu_issue_stage_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [31:0]       ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [31:0]       rb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [31:0]       wd
);

   logic [31:0] regs [REG_COUNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
      rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
      dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand/writeback stage around an external registered ALU. Accepts one
//   instruction at a time (valid/ready), reads operands, enables the ALU for
//   one cycle, writes the registered ALU result back, and supports a
//   load-immediate path. Illegal opcodes retire with err and no side effects.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   in_valid, in_ready               instruction handshake (ready only in IDLE)
//   in_load, in_op, in_rd, in_rs,
//   in_rt, in_imm                    instruction fields
//   alu_a, alu_b, alu_op, alu_enable ALU drive (registered)
//   alu_out, alu_zero                ALU registered result / Zero
//   done, err                        one-cycle retire pulse / illegal-op flag
//   result, zero_flag                last retired value / last ALU Zero (held)
//   dbg_addr, dbg_data               combinational register debug read
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [31:0]       in_imm,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_op,
   output logic              alu_enable,
   input  logic [31:0]       alu_out,
   input  logic              alu_zero,
   output logic              done,
   output logic              err,
   output logic [31:0]       result,
   output logic              zero_flag,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data
);

   state_t            state;
   logic [ADDR_W-1:0] lat_rd;
   logic [31:0]       lat_imm;
   logic [31:0]       rd_a;
   logic [31:0]       rd_b;
   logic              wb_we;
   logic [31:0]       wb_data;

   alu_issue_stage_regfile #(
      .REG_COUNT (REG_COUNT),
      .ADDR_W    (ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (in_rs),
      .ra_data  (rd_a),
      .rb_addr  (in_rt),
      .rb_data  (rd_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (wb_we),
      .wa       (lat_rd),
      .wd       (wb_data)
   );

   always_comb begin
      wb_we   = (state == ST_WB) || (state == ST_LDWB);
      wb_data = (state == ST_WB) ? alu_out : lat_imm;
   end

   // Operands are sampled into the registered ALU inputs on the accept edge,
   // so they are stable throughout ISSUE. No writeback can be pending when an
   // instruction is accepted, so this returns the same values as a read
   // performed in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         result     <= '0;
         zero_flag  <= 1'b0;
         alu_enable <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         lat_rd     <= '0;
         lat_imm    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  lat_rd   <= in_rd;
                  lat_imm  <= in_imm;
                  in_ready <= 1'b0;
                  if (in_load) begin
                     state <= ST_LDWB;
                  end else if (!is_legal_op(in_op)) begin
                     state <= ST_ERR;
                  end else begin
                     state      <= ST_ISSUE;
                     alu_enable <= 1'b1;
                     alu_a      <= rd_a;
                     alu_b      <= rd_b;
                     alu_op     <= in_op;
                  end
               end
            end
            ST_ISSUE: begin
               alu_enable <= 1'b0;
               state      <= ST_WB;
            end
            ST_WB: begin
               result    <= alu_out;
               zero_flag <= alu_zero;
               done      <= 1'b1;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
            ST_LDWB: begin
               result   <= lat_imm;
               done     <= 1'b1;
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
            ST_ERR: begin
               done     <= 1'b1;
               err      <= 1'b1;
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage. Provides a behavioural registered
//   ALU (single-position shifts/rotates) and a reference register-file model.
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_load;
   logic [3:0]  in_op;
   logic [4:0]  in_rd, in_rs, in_rt, dbg_addr;
   logic [31:0] in_imm, alu_a, alu_b, dbg_data, result;
   logic [3:0]  alu_op;
   logic        alu_enable, done, err, zero_flag;
   logic [31:0] alu_out  = 32'hDEAD_BEEF;
   logic        alu_zero = 1'b1;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ref_regs [32];
   logic [31:0] ref_result;
   logic        ref_zero;
   int          exp_lat;
   logic        exp_err;

   always #5 clk = ~clk;

   alu_issue_stage #(.REG_COUNT(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
      .in_rt(in_rt), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_enable(alu_enable), .alu_out(alu_out),
      .alu_zero(alu_zero), .done(done), .err(err), .result(result),
      .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_NOT:  return ~a;
         OP_ASR:  return {a[31], a[31:1]};
         OP_SLL:  return {a[30:0], 1'b0};
         OP_SRL:  return {1'b0, a[31:1]};
         OP_ROL:  return {a[30:0], a[31]};
         OP_ROR:  return {a[0], a[31:1]};
         default: return 32'h0;
      endcase
   endfunction

   // External ALU: registers Out/Zero only while enabled, never reset.
   always @(posedge clk) begin
      if (alu_enable) begin
         alu_out  <= ref_alu(alu_op, alu_a, alu_b);
         alu_zero <= (ref_alu(alu_op, alu_a, alu_b) == 32'h0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      ref_result = 32'h0;
      ref_zero   = 1'b0;
   endtask

   // Architectural effect of one instruction, plus expected latency/err.
   task automatic model_apply(input logic ld, input logic [3:0] op, input logic [4:0] rd,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
      logic [31:0] v;
      if (ld) begin
         if (rd != 0) ref_regs[rd] = imm;
         ref_result = imm;
         exp_lat = 2; exp_err = 1'b0;
      end else if (!(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_ASR, OP_SLL, OP_SRL, OP_ROL, OP_ROR})) begin
         exp_lat = 2; exp_err = 1'b1;
      end else begin
         v = ref_alu(op, ref_regs[rs], ref_regs[rt]);
         if (rd != 0) ref_regs[rd] = v;
         ref_result = v;
         ref_zero   = (v == 32'h0);
         exp_lat = 3; exp_err = 1'b0;
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic send(input logic ld, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] imm, output int lat, output int en, output logic e);
      int guard = 0;
      lat = 99; en = 0; e = 1'bx;
      while (!in_ready && guard < 10) begin @(negedge clk); guard++; end
      in_valid = 1'b1; in_load = ld; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 4'($urandom); in_rd = 5'($urandom); in_rs = 5'($urandom);
      in_rt = 5'($urandom); in_imm = $urandom; in_load = 1'($urandom);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (alu_enable) en++;
         if (done) begin lat = n; e = err; break; end
      end
   endtask

   task automatic exec(input logic ld, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] imm, output int lat, output int en, output logic e);
      model_apply(ld, op, rd, rs, rt, imm);
      send(ld, op, rd, rs, rt, imm, lat, en, e);
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] d);
      dbg_addr = a; #1; d = dbg_data;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, done, err, zero_flag, alu_enable} !== 5'b10000) begin
         failures++; $display("FAIL reset_ctrl: got rdy/done/err/zf/en=%b required 10000", {in_ready, done, err, zero_flag, alu_enable});
      end
      checks++;
      if ({result, alu_a, alu_b, alu_op} !== 100'h0) begin
         failures++; $display("FAIL reset_data: got result=%h a=%h b=%h op=%h required all 0", result, alu_a, alu_b, alu_op);
      end
      rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), d); checks++;
         if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d: got %h required 0", i, d); end
      end
   endtask

   task automatic test_add();
      int lat, en; logic e; logic [31:0] d;
      exec(1'b1, 4'h0, 5'd1, 5'd0, 5'd0, 32'd5, lat, en, e);
      checks++;
      if (lat !== 2 || result !== 32'd5 || e !== 1'b0) begin
         failures++; $display("FAIL load_r1: got lat=%0d result=%h err=%b required 2/5/0", lat, result, e);
      end
      exec(1'b1, 4'h0, 5'd2, 5'd0, 5'd0, 32'd3, lat, en, e);
      exec(1'b0, OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, lat, en, e);
      checks++;
      if (en !== 1 || lat !== 3) begin
         failures++; $display("FAIL add_timing: got enable_cycles=%0d lat=%0d required 1/3", en, lat);
      end
      peek(5'd3, d); checks++;
      if (result !== 32'd8 || zero_flag !== 1'b0 || e !== 1'b0 || d !== 32'd8) begin
         failures++; $display("FAIL add_value: got result=%h zf=%b err=%b r3=%h required 8/0/0/8", result, zero_flag, e, d);
      end
   endtask

   task automatic test_sub_zero();
      int lat, en; logic e; logic [31:0] d;
      exec(1'b0, OP_SUB, 5'd4, 5'd2, 5'd2, 32'h0, lat, en, e);
      peek(5'd4, d); checks++;
      if (result !== 32'h0 || zero_flag !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
         failures++; $display("FAIL sub_zero: got result=%h zf=%b err=%b r4=%h required 0/1/0/0", result, zero_flag, e, d);
      end
   endtask

   task automatic test_shift_rotate();
      int lat, en; logic e; logic [31:0] d;
      exec(1'b1, 4'h0, 5'd5, 5'd0, 5'd0, 32'h8000_0001, lat, en, e);
      exec(1'b0, OP_ROL, 5'd6, 5'd5, 5'd0, 32'h0, lat, en, e);
      peek(5'd6, d); checks++;
      if (d !== 32'h0000_0003 || result !== 32'h0000_0003) begin
         failures++; $display("FAIL rol: got r6=%h result=%h required 00000003", d, result);
      end
      exec(1'b0, OP_ASR, 5'd7, 5'd5, 5'd0, 32'h0, lat, en, e);
      peek(5'd7, d); checks++;
      if (d !== 32'hC000_0000 || result !== 32'hC000_0000) begin
         failures++; $display("FAIL asr: got r7=%h result=%h required c0000000", d, result);
      end
   endtask

   task automatic test_illegal();
      int lat, en; logic e; logic [31:0] d;
      exec(1'b0, 4'b0101, 5'd3, 5'd1, 5'd2, 32'h0, lat, en, e);
      checks++;
      if (en !== 0 || lat !== 2 || e !== 1'b1) begin
         failures++; $display("FAIL illegal_ctrl: got enable_cycles=%0d lat=%0d err=%b required 0/2/1", en, lat, e);
      end
      checks++;
      if (result !== ref_result || zero_flag !== ref_zero) begin
         failures++; $display("FAIL illegal_hold: got result=%h zf=%b required %h/%b", result, zero_flag, ref_result, ref_zero);
      end
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), d); checks++;
         if (d !== ref_regs[i]) begin failures++; $display("FAIL illegal_reg%0d: got %h required %h", i, d, ref_regs[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int acc = 0, ndone = 0, en = 0, lat; logic e;
      int acc_c[$]; int done_c[$]; logic [31:0] exp_q[$]; logic [31:0] x;
      logic [31:0] d;
      in_valid = 1'b1; in_load = 1'b0; in_op = OP_ADD; in_rd = 5'd8; in_rs = 5'd1; in_rt = 5'd8; in_imm = 32'h0;
      for (int c = 0; c < 14; c++) begin
         if (alu_enable) en++;
         if (done) begin
            ndone++; done_c.push_back(c);
            x = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
            checks++;
            if (result !== x || err !== 1'b0) begin
               failures++; $display("FAIL b2b_result%0d: got %h err=%b required %h/0", ndone, result, err, x);
            end
         end
         if (in_valid && in_ready) begin
            model_apply(1'b0, OP_ADD, 5'd8, 5'd1, 5'd8, 32'h0);
            exp_q.push_back(ref_result);
            acc++; acc_c.push_back(c);
         end
         @(posedge clk); #1;
         if (acc == 3) in_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (acc !== 3 || ndone !== 3 || en !== 3) begin
         failures++; $display("FAIL b2b_counts: got accepts=%0d dones=%0d enables=%0d required 3/3/3", acc, ndone, en);
      end else begin
         checks++;
         if (acc_c[1] - acc_c[0] != 3 || acc_c[2] - acc_c[1] != 3 || done_c[0] - acc_c[0] != 3 ||
             done_c[1] - done_c[0] != 3 || done_c[2] - done_c[1] != 3) begin
            failures++; $display("FAIL b2b_spacing: got accepts=%0d,%0d,%0d dones=%0d,%0d,%0d required spacing 3",
                                 acc_c[0], acc_c[1], acc_c[2], done_c[0], done_c[1], done_c[2]);
         end
      end
      exec(1'b1, 4'h0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, lat, en, e);
      peek(5'd0, d); checks++;
      if (d !== 32'h0 || result !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL load_r0: got r0=%h result=%h required 0/ffffffff", d, result);
      end
   endtask

   task automatic test_reset_mid();
      int lat, en, seen = 0; logic e; logic [31:0] d;
      in_valid = 1'b1; in_load = 1'b0; in_op = OP_ADD; in_rd = 5'd9; in_rs = 5'd1; in_rt = 5'd2;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (alu_enable !== 1'b1) begin failures++; $display("FAIL midrst_issue: got alu_enable=%b required 1", alu_enable); end
      rst_n = 1'b0; #1;
      model_clear();
      peek(5'd1, d); checks++;
      if (in_ready !== 1'b1 || alu_enable !== 1'b0 || done !== 1'b0 || d !== 32'h0 || result !== 32'h0) begin
         failures++; $display("FAIL midrst_state: got rdy=%b en=%b done=%b r1=%h result=%h required 1/0/0/0/0",
                              in_ready, alu_enable, done, d, result);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done) seen++; end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL midrst_nodone: got %0d done pulses required 0", seen); end
      exec(1'b1, 4'h0, 5'd1, 5'd0, 5'd0, 32'd7, lat, en, e);
      exec(1'b1, 4'h0, 5'd2, 5'd0, 5'd0, 32'd9, lat, en, e);
      exec(1'b0, OP_ADD, 5'd9, 5'd1, 5'd2, 32'h0, lat, en, e);
      peek(5'd9, d); checks++;
      if (lat !== 3 || result !== 32'd16 || d !== 32'd16) begin
         failures++; $display("FAIL midrst_after: got lat=%0d result=%h r9=%h required 3/10/10", lat, result, d);
      end
   endtask

   task automatic test_random();
      int lat, en; logic e; logic [31:0] d;
      logic [3:0] ops [10];
      logic ld; logic [3:0] op; logic [4:0] rd, rs, rt; logic [31:0] imm;
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_ASR, OP_SLL, OP_SRL, OP_ROL, OP_ROR};
      for (int k = 0; k < 60; k++) begin
         ld  = ($urandom_range(0, 3) == 0);
         op  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
         rd  = 5'($urandom_range(0, 7)); rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
         imm = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         exec(ld, op, rd, rs, rt, imm, lat, en, e);
         checks++;
         if (lat !== exp_lat || e !== exp_err || result !== ref_result || zero_flag !== ref_zero) begin
            failures++; $display("FAIL rand%0d: got lat=%0d err=%b result=%h zf=%b required %0d/%b/%h/%b",
                                 k, lat, e, result, zero_flag, exp_lat, exp_err, ref_result, ref_zero);
         end
      end
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), d); checks++;
         if (d !== ref_regs[i]) begin failures++; $display("FAIL rand_reg%0d: got %h required %h", i, d, ref_regs[i]); end
      end
   endtask

   initial begin
      in_valid = 1'b0; in_load = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
      in_imm = '0; dbg_addr = '0; rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      test_reset();
      @(negedge clk);
      test_add();
      test_sub_zero();
      test_shift_rotate();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand/writeback stage wrapped around the ALU. It holds the architectural register file and accepts one instruction at a time over a valid/ready handshake. For each operation it reads the operands, drives the ALU for one enabled cycle, captures the registered result and Zero flag, and writes the result back. It also supports a load-immediate path so software and benches can initialise registers.

Parameters:
REG_COUNT, 32, number of 32-bit registers; R0 reads as zero and ignores writes
ADDR_W, 5, register index width; must satisfy 2**ADDR_W == REG_COUNT

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  high only in IDLE; transfer when in_valid && in_ready
in_load  in  1  1 = load-immediate, 0 = ALU operation
in_op  in  4  ALU opcode
in_rd  in  ADDR_W  destination register
in_rs  in  ADDR_W  source for ALU A
in_rt  in  ADDR_W  source for ALU B
in_imm  in  32  immediate for load
alu_a  out  32  to ALU A
alu_b  out  32  to ALU B
alu_op  out  4  to ALU Op
alu_enable  out  1  to ALU enable
alu_out  in  32  from ALU Out (registered inside the ALU)
alu_zero  in  1  from ALU Zero
done  out  1  one-cycle pulse when an instruction retires
err  out  1  valid with done; 1 = illegal opcode
result  out  32  value retired; held until the next done
zero_flag  out  1  Zero of last retired ALU op; held
dbg_addr  in  ADDR_W  debug read index
dbg_data  out  32  combinational R[dbg_addr]

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; all registers 0; in_ready=1; done=0; err=0; result=0; zero_flag=0; alu_enable=0; alu_a/alu_b/alu_op=0. The ALU has no reset, so its stale Out is ignored until the next WB.
- Legal opcodes: 0000, 0001, 0010, 0011, 0100, 1000, 1001, 1010, 1100, 1101. All other opcodes are illegal.
- FSM states: IDLE, ISSUE, WB, LDWB, ERR.
- IDLE: in_ready=1. On transfer, latch rd/rs/rt/op/imm, then:
  - in_load=1 -> LDWB
  - illegal opcode -> ERR
  - otherwise -> ISSUE
- ISSUE, 1 cycle: alu_enable=1; alu_a=R[rs]; alu_b=R[rt]; alu_op=latched op. The ALU registers its Out at the closing edge. Next state is WB.
- WB, 1 cycle: alu_enable=0. At the closing edge:
  - R[rd] <= alu_out (skipped if rd=0)
  - result <= alu_out; zero_flag <= alu_zero
  - done=1, err=0 in the following cycle
  - next state IDLE
- LDWB, 1 cycle: R[rd] <= imm (skipped if rd=0); result <= imm; zero_flag unchanged; done pulse; next state IDLE.
- ERR, 1 cycle: no ALU enable; registers, result and zero_flag unchanged; done=1, err=1; next state IDLE.
- done/err are registered. They are high for exactly the cycle after WB/LDWB/ERR, which coincides with IDLE, so a new transfer may happen in that same cycle.
- Latency, accept edge to done high: ALU op 3 cycles; load 2 cycles; illegal 2 cycles. Throughput is one instruction per 3 or 2 cycles.
- Outside IDLE, in_ready=0; in_valid is ignored and the fields need not be held.
- Reading a register written in the same cycle returns the old value. rs=rt is legal. rd equal to rs or rt is legal, since operands are read in ISSUE, before WB.
- R0 always reads 0, on operand and debug ports alike.
- Reset mid-operation aborts the instruction: no writeback and no done.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_NOT=0100, OP_ASR=1000, OP_SLL=1001, OP_SRL=1010, OP_ROL=1100, OP_ROR=1101
  - an is_legal_op function
  - FSM state encoding
- One natural sub-module: regfile. It has two combinational read ports plus the debug port, one synchronous write port, asynchronous clear, and R0 hardwired to zero.
- The FSM and handshake stay in the top module.

Test Plan:
- Load R1=5, R2=3, then ADD rd=3 rs=1 rt=2 -> alu_enable high for exactly 1 cycle; done 3 cycles after accept; result=8, zero_flag=0, R3=8.
- SUB rd=4 rs=2 rt=2 -> R4=0, result=0, zero_flag=1, err=0.
- Load R5=0x80000001, ROL rd=6 rs=5 -> R6=0x00000003; ASR rd=7 rs=5 -> R7=0xC0000000.
- Opcode 0101 -> alu_enable never asserted; done with err=1 two cycles after accept; all registers and result unchanged.
- in_valid held high over 3 back-to-back ADDs -> in_ready low in ISSUE/WB; each accepted only in IDLE; 3 done pulses, 3 cycles apart. Load rd=0 with imm=0xFFFFFFFF -> dbg_data for R0 stays 0, result=0xFFFFFFFF.
- Assert rst_n low during ISSUE of an ADD -> immediately all registers 0, in_ready=1, no done; next instruction executes normally.
